// File: rtl/fanout_pkg.sv
// Shared definitions for the fanout skid driver.
//   cnt_e          : buffer occupancy state (EMPTY, ONE, TWO), 2-bit encoding.
//   DEF_WIDTH      : default data word width.
//   DEF_NUM_LOADS  : default number of broadcast consumers.
package fanout_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } cnt_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_LOADS = 3;

endpackage

// File: rtl/fanout_ack_tracker.sv
// Tracks which consumers have already taken the current head word.
// Ports:
//   clk        : clock, rising edge.
//   rst_n      : synchronous active-low reset.
//   head_valid : a head word is present (occupancy != EMPTY).
//   out_ready  : per-consumer ready.
//   out_valid  : per-consumer valid; low once that consumer has fired.
//   all_done   : every consumer has taken (or is taking now) the head.
module fanout_ack_tracker
  import fanout_pkg::*;
#(
  parameter int NUM_LOADS = DEF_NUM_LOADS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 head_valid,
  input  logic [NUM_LOADS-1:0] out_ready,
  output logic [NUM_LOADS-1:0] out_valid,
  output logic                 all_done
);

  logic [NUM_LOADS-1:0] done_q;
  logic [NUM_LOADS-1:0] done_d;
  logic [NUM_LOADS-1:0] fire;

  // A consumer that already took the head sees valid low, so its ready
  // is ignored until the next head.
  assign out_valid = {NUM_LOADS{head_valid}} & ~done_q;
  assign fire      = out_valid & out_ready;

  // Retire when the remaining consumers all fire this cycle, including the
  // case where every consumer fires at once.
  assign all_done  = head_valid & (&(done_q | fire));

  always_comb begin
    done_d = done_q | fire;
    if (all_done) begin
      done_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/fanout_skid_driver.sv
// Registered stream driver: a 2-entry skid buffer whose head word is
// broadcast to NUM_LOADS consumers, each with its own valid/ready pair.
// The head retires only after every consumer has accepted it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and in_ready is decoded from
// registered state only (no path from out_ready or in_valid).
//
// Ports:
//   clk, rst_n : clock and synchronous active-low reset.
//   in_valid, in_ready, in_data : upstream stream.
//   out_valid, out_ready        : per-consumer handshake.
//   out_data                    : head word, shared by all consumers.
//   busy                        : buffer holds at least one word.
//   dbg_cnt                     : occupancy state, for observation only.
module fanout_skid_driver
  import fanout_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_LOADS = DEF_NUM_LOADS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NUM_LOADS-1:0] out_valid,
  input  logic [NUM_LOADS-1:0] out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 busy,
  output cnt_e                 dbg_cnt
);

  cnt_e             cnt_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             head_valid;
  logic             accept;
  logic             retire;

  assign head_valid = (cnt_q != EMPTY);
  assign in_ready   = rst_n & (cnt_q != TWO);
  assign accept     = in_valid & in_ready;
  assign busy       = head_valid;
  assign out_data   = head_q;
  assign dbg_cnt    = cnt_q;

  fanout_ack_tracker #(
    .NUM_LOADS (NUM_LOADS)
  ) u_ack (
    .clk        (clk),
    .rst_n      (rst_n),
    .head_valid (head_valid),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .all_done   (retire)
  );

  // head_q only changes when a new word becomes head, so out_data is stable
  // for as long as any consumer still sees valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      case (cnt_q)
        EMPTY: begin
          if (accept) begin
            head_q <= in_data;
            cnt_q  <= ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            head_q <= in_data;
          end else if (accept) begin
            skid_q <= in_data;
            cnt_q  <= TWO;
          end else if (retire) begin
            cnt_q  <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a retire can move the state.
          if (retire) begin
            head_q <= skid_q;
            cnt_q  <= ONE;
          end
        end
        default: begin
          cnt_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fanout_skid_driver.sv
module tb_fanout_skid_driver;
  import fanout_pkg::*;

  localparam int W = 8;
  localparam int L = 3;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [L-1:0] out_valid;
  logic [L-1:0] out_ready = '0;
  logic [W-1:0] out_data;
  logic         busy;
  cnt_e         dbg_cnt;

  always #5 clk = ~clk;

  fanout_skid_driver #(.WIDTH(W), .NUM_LOADS(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_cnt   (dbg_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [L-1:0] r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // ---------------- scoreboard ----------------
  // Expected words in FIFO order; taken marks consumers that already got
  // the front word.
  logic [W-1:0] exp_q[$];
  logic [L-1:0] taken = '0;

  always @(negedge clk) begin
    logic [L-1:0] exp_ov;
    logic [L-1:0] fire;
    logic         acc;
    if (!rst_n) begin
      exp_q.delete();
      taken = '0;
    end else begin
      exp_ov = (exp_q.size() != 0) ? ~taken : '0;
      acc    = in_valid && (exp_q.size() < 2);
      check("sb_out_valid", 32'(out_valid), 32'(exp_ov));
      check("sb_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      check("sb_busy", 32'(busy), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        fire = exp_ov & out_ready;
        if (fire != '0) check("sb_out_data", 32'(out_data), 32'(exp_q[0]));
        taken = taken | fire;
        if (&taken) begin
          void'(exp_q.pop_front());
          taken = '0;
        end
      end
      if (acc) exp_q.push_back(in_data);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic         in_valid;
    logic [W-1:0] in_data;
    logic [L-1:0] out_ready;
    logic         exp_in_ready;
    logic [L-1:0] exp_out_valid;
    logic         exp_busy;
  } vec_t;

  vec_t vt[7];

  initial begin
    // Staggered consumers on 0x5A: load 0, then load 2, then load 1.
    vt[0] = '{1'b1, 8'h5A, 3'b000, 1'b1, 3'b111, 1'b1};
    vt[1] = '{1'b0, 8'h00, 3'b001, 1'b1, 3'b110, 1'b1};
    vt[2] = '{1'b0, 8'h00, 3'b000, 1'b1, 3'b110, 1'b1};
    vt[3] = '{1'b0, 8'h00, 3'b100, 1'b1, 3'b010, 1'b1};
    vt[4] = '{1'b0, 8'h00, 3'b000, 1'b1, 3'b010, 1'b1};
    vt[5] = '{1'b0, 8'h00, 3'b010, 1'b1, 3'b000, 1'b0};
    vt[6] = '{1'b0, 8'h00, 3'b001, 1'b1, 3'b000, 1'b0};

    // Reset state.
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'h1);

    // Table-driven staggered consumers.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].in_valid, vt[i].in_data, vt[i].out_ready);
      step();
      check("tbl_in_ready", 32'(in_ready), 32'(vt[i].exp_in_ready));
      check("tbl_out_valid", 32'(out_valid), 32'(vt[i].exp_out_valid));
      check("tbl_busy", 32'(busy), 32'(vt[i].exp_busy));
      if (vt[i].exp_busy) check("tbl_out_data", 32'(out_data), 32'h5A);
    end

    // Full-rate broadcast 0x01..0x08.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, W'(k), 3'b111);
      step();
      check("full_out_data", 32'(out_data), 32'(k));
      check("full_out_valid", 32'(out_valid), 32'h7);
      check("full_in_ready", 32'(in_ready), 32'h1);
    end
    drive(1'b0, 8'h00, 3'b111);
    step();
    check("full_drain_busy", 32'(busy), 32'h0);

    // Backpressure to full, then release.
    drive(1'b1, 8'h11, 3'b000); step();
    drive(1'b1, 8'h22, 3'b000); step();
    drive(1'b1, 8'h33, 3'b000); step();
    check("bp_cnt", 32'(dbg_cnt), 32'(TWO));
    check("bp_in_ready", 32'(in_ready), 32'h0);
    check("bp_head", 32'(out_data), 32'h11);
    out_ready = 3'b111; step();
    check("bp_head2", 32'(out_data), 32'h22);
    step();
    check("bp_head3", 32'(out_data), 32'h33);
    check("bp_cnt_one", 32'(dbg_cnt), 32'(ONE));
    drive(1'b0, 8'h00, 3'b111); step();
    check("bp_empty", 32'(busy), 32'h0);

    // Simultaneous accept and retire while in ONE.
    drive(1'b1, 8'h44, 3'b000); step();
    drive(1'b0, 8'h00, 3'b101); step();
    check("sim_wait_load1", 32'(out_valid), 32'h2);
    drive(1'b1, 8'h55, 3'b010); step();
    check("sim_head", 32'(out_data), 32'h55);
    check("sim_cnt", 32'(dbg_cnt), 32'(ONE));
    check("sim_out_valid", 32'(out_valid), 32'h7);
    drive(1'b0, 8'h00, 3'b111); step();
    check("sim_empty", 32'(busy), 32'h0);

    // Ready held on a consumer that already fired is ignored.
    drive(1'b1, 8'h66, 3'b000); step();
    drive(1'b0, 8'h00, 3'b001);
    for (int k = 0; k < 4; k++) begin
      step();
      check("ign_out_valid", 32'(out_valid), 32'h6);
      check("ign_busy", 32'(busy), 32'h1);
    end
    out_ready = 3'b111; step();
    check("ign_empty", 32'(busy), 32'h0);

    // Reset mid-stream with the buffer full.
    drive(1'b1, 8'hA1, 3'b000); step();
    drive(1'b1, 8'hB2, 3'b000); step();
    check("mrst_full", 32'(dbg_cnt), 32'(TWO));
    drive(1'b0, 8'h00, 3'b000);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready_low", 32'(in_ready), 32'h0);
    step();
    check("mrst_out_valid", 32'(out_valid), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b1;
    out_ready = 3'b111;
    #1;
    check("mrst_in_ready_after", 32'(in_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mrst_no_emit", 32'(out_valid), 32'h0);
    end

    // Random traffic against the scoreboard.
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), L'($urandom_range(0, 7)));
      step();
    end

    // Bounded drain.
    drive(1'b0, 8'h00, 3'b111);
    for (int k = 0; k < 10 && busy; k++) step();
    check("drain_busy", 32'(busy), 32'h0);
    step();
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
